// File: rtl/cordic_mag_buffer_if.sv
// Handshake bundle between the CORDIC magnitude pipeline, its upstream
// issuer, the output elastic buffer and the downstream consumer.
interface cordic_mag_buffer_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             issue_i;
   logic             issue_ok_o;
   logic             valid_i;
   logic [WIDTH-1:0] data_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] data_o;
   logic [CW-1:0]    count_o;
   logic [CW-1:0]    credits_o;
   logic             overflow_o;
   logic             issue_err_o;

   // Buffer side: receives issue/pipeline/consumer inputs, drives status and head.
   modport slave (
      input  issue_i,
      input  valid_i,
      input  data_i,
      input  ready_i,
      output issue_ok_o,
      output valid_o,
      output data_o,
      output count_o,
      output credits_o,
      output overflow_o,
      output issue_err_o
   );

   // Environment side: upstream issuer, pipeline output and consumer.
   modport master (
      output issue_i,
      output valid_i,
      output data_i,
      output ready_i,
      input  issue_ok_o,
      input  valid_o,
      input  data_o,
      input  count_o,
      input  credits_o,
      input  overflow_o,
      input  issue_err_o
   );
endinterface

// File: rtl/cordic_mag_buffer.sv
// Elastic output buffer for the CORDIC magnitude pipeline. The pipeline
// cannot be stalled, so the upstream issuer is throttled by credits: a
// credit is reserved when a sample is issued and returned only when the
// consumer pops the matching result, so in-flight plus buffered samples
// never exceed DEPTH.
module cordic_mag_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   cordic_mag_buffer_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    wr_ptr;
   logic [CW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    credits;
   logic [CW-1:0]    credits_nxt;
   logic             overflow;
   logic             issue_err;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             take;

   // Occupancy comes straight from the extra-bit pointers; wrap is natural.
   always_comb begin
      count = wr_ptr - rd_ptr;
      full  = (count == DEPTH_CW);
      empty = (count == '0);
   end

   // Per-cycle events. A full FIFO still accepts a sample when the head
   // leaves in the same cycle, so a steady stream never drops at full.
   always_comb begin
      pop  = !empty && bus.ready_i;
      push = bus.valid_i && (!full || pop);
      take = bus.issue_i && (credits != '0);
   end

   // Pointer update; reset discards buffered data by collapsing both pointers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Sample storage; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.data_i;
   end

   // Credit arithmetic: reserve on take, return on pop, saturate at both ends.
   always_comb begin
      credits_nxt = credits;
      if (take && !pop) begin
         credits_nxt = credits - 1'b1;
      end else if (pop && !take && (credits != DEPTH_CW)) begin
         credits_nxt = credits + 1'b1;
      end
   end

   // Credit register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) credits <= DEPTH_CW;
      else       credits <= credits_nxt;
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow  <= 1'b0;
         issue_err <= 1'b0;
      end else begin
         if (bus.valid_i && !push)            overflow  <= 1'b1;
         if (bus.issue_i && (credits == '0))  issue_err <= 1'b1;
      end
   end

   // Output drive; data reads as zero whenever the FIFO is empty.
   always_comb begin
      bus.valid_o     = !empty;
      bus.data_o      = empty ? '0 : mem[rd_ptr[AW-1:0]];
      bus.count_o     = count;
      bus.credits_o   = credits;
      bus.issue_ok_o  = (credits != '0);
      bus.overflow_o  = overflow;
      bus.issue_err_o = issue_err;
   end
endmodule

// File: doc/cordic_mag_buffer.md
Name: cordic_mag_buffer

Overview:
Output-side elastic buffer that sits directly downstream of the CORDIC magnitude pipeline. The pipeline has no backpressure, so this block provides it.
- Captures every valid magnitude into a FIFO and presents it to the consumer on a valid/ready interface.
- Runs a credit counter and drives issue_ok_o. The upstream source issues a new x/y pair into the pipeline only while issue_ok_o is high, so in-flight plus buffered samples never exceed DEPTH.

Parameters:
WIDTH, 32, data width; must match the magnitude width produced by the pipeline.
DEPTH, 32, FIFO entries; power of 2, >= 2. Must be >= pipeline latency (WIDTH/2+1) for full throughput.
CW, $clog2(DEPTH)+1, counter width (derived, not overridden).

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
issue_i  in  1  upstream is launching a sample into the pipeline this cycle
issue_ok_o  out  1  a credit is free; upstream may issue
valid_i  in  1  pipeline output valid
data_i  in  WIDTH  pipeline magnitude
valid_o  out  1  FIFO head valid
ready_i  in  1  consumer accepts head
data_o  out  WIDTH  FIFO head data
count_o  out  CW  FIFO occupancy
credits_o  out  CW  free credits (DEPTH - reserved)
overflow_o  out  1  sticky: a valid_i sample was dropped
issue_err_o  out  1  sticky: issue_i was asserted while issue_ok_o was low

Behaviour:
Reset: async assert, sync release. While rst_i is high, all of the following hold:
- rd/wr pointers = 0, count_o = 0, credits_o = DEPTH.
- valid_o = 0, data_o = 0, issue_ok_o = 1.
- overflow_o = 0, issue_err_o = 0.
- Reset mid-operation discards all buffered data and credits immediately.

Events per cycle:
- push = valid_i && (count < DEPTH || pop).
- pop = valid_o && ready_i.
- take = issue_i && issue_ok_o.

FIFO:
- Circular buffer; pointers are log2(DEPTH)+1 bits and wrap naturally. full = count == DEPTH, empty = count == 0.
- valid_o = !empty. data_o = mem[rd_ptr] (head of FIFO).
- No bypass: a sample pushed into an empty FIFO appears on valid_o/data_o the next cycle (latency 1).
- Head is stable: data_o holds while valid_o && !ready_i.
- count_next = count + push - pop. Push and pop in the same cycle leave count unchanged, including at full and at empty+push.
- Full with valid_i, no pop: sample dropped, overflow_o set next cycle and held until reset. FIFO content is unchanged.
- ready_i while empty: no effect.

Credits:
- issue_ok_o = credits_o != 0, driven combinationally from the register.
- credits_next = credits - take + pop. Simultaneous take and pop leave credits unchanged.
- Credits are returned on pop, not on push.
- issue_i with credits == 0: no credit change; issue_err_o set (sticky).
- Credits never underflow below 0 or exceed DEPTH.
- Invariant under correct upstream use: in-flight + count_o == DEPTH - credits_o.
- The block does not track latency. Correctness relies only on the pipeline being lossless and in-order.

Test Plan:
1. Reset, then idle -> valid_o=0, count_o=0, credits_o=32, issue_ok_o=1, both error flags 0.
2. issue_i for 1 cycle, then valid_i with data_i=0x0005_0000 seventeen cycles later, ready_i=1:
   - credits_o=31 after the issue; valid_o=1 with data_o=0x0005_0000 one cycle after valid_i.
   - After the pop, credits_o=32 and count_o=0.
3. ready_i=0, 32 issues and 32 pushed samples 1..32:
   - credits_o=0 and issue_ok_o=0 after the 32nd issue; count_o=32.
   - Then ready_i=1 -> data_o sequence 1..32 in order, credits_o returns to 32.
4. FIFO full (32 entries), valid_i=1 with ready_i=1 in the same cycle -> head popped, new sample accepted, count_o stays 32, overflow_o=0.
5. FIFO full, ready_i=0, valid_i=1 with data_i=0xDEAD -> overflow_o=1 next cycle and stays set; draining yields only the original 32 values.
6. Credits=0, issue_i=1 -> issue_err_o=1, credits_o stays 0. Then assert rst_i mid-stream with count_o=10 -> same cycle: valid_o=0, count_o=0, credits_o=32, both flags cleared.
